// File: rtl/collision_hp_tracker_pkg.sv
// Shared game definitions for the collision / hit-point tracker.
// Holds the tracker state encoding, default player size and hit points,
// coordinate widths, and a small range-test helper.
package collision_hp_tracker_pkg;

  localparam int unsigned COORD_W         = 12;
  localparam int unsigned HP_W            = 4;
  localparam int unsigned PLAYER_SIZE_DEF = 20;
  localparam int unsigned MAX_HP_DEF      = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_INVULN    = 2'd2,
    ST_GAME_OVER = 2'd3
  } hp_state_e;

  // True when lo <= pos <= hi (unsigned).
  function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                   input logic [COORD_W-1:0] lo,
                                   input logic [COORD_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/collision_hp_tracker_timer.sv
// Invulnerability countdown with blink divider.
// Ports:
//   pclk, rst    clock / synchronous active-high reset
//   load         start a window: count <= CYCLES-1, blink <= 0
//   run          count down one step per cycle while the window is open
//   clear        abandon the window (count, divider and blink cleared)
//   done_c       count has reached zero (combinational from the counter)
//   blink        toggles every BLINK_HALF cycles of the window, 0 outside it
module hp_countdown_timer #(
  parameter int unsigned CYCLES     = 65000000,
  parameter int unsigned BLINK_HALF = 8125000
) (
  input  logic pclk,
  input  logic rst,
  input  logic load,
  input  logic run,
  input  logic clear,
  output logic done_c,
  output logic blink
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int unsigned DIV_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] count;
  logic [DIV_W-1:0] div;

  // Countdown and blink divider; the final run step (count already 0) drops blink.
  always_ff @(posedge pclk) begin
    if (rst || clear) begin
      count <= '0;
      div   <= '0;
      blink <= 1'b0;
    end else if (load) begin
      count <= CNT_LOAD;
      div   <= DIV_LOAD;
      blink <= 1'b0;
    end else if (run) begin
      if (count == '0) begin
        blink <= 1'b0;
      end else begin
        count <= count - CNT_W'(1);
        if (div == '0) begin
          div   <= DIV_LOAD;
          blink <= ~blink;
        end else begin
          div <= div - DIV_W'(1);
        end
      end
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/collision_hp_tracker.sv
// Player collision detection and hit-point bookkeeping.
// Ports:
//   pclk, rst                 pixel clock / synchronous active-high reset
//   obstacle_x, obstacle_y    obstacle pixel being drawn, (0,0) = none
//   player_x, player_y        player square top-left corner
//   play_selected, menu_on    session active / menu shown (abort)
//   hp                        remaining hit points
//   hit                       one-cycle pulse per accepted collision
//   invuln, blink             invulnerability window and its blink toggle
//   game_over                 out of hit points
module collision_hp_tracker
  import collision_hp_tracker_pkg::*;
#(
  parameter int unsigned PLAYER_SIZE   = PLAYER_SIZE_DEF,
  parameter int unsigned MAX_HP        = MAX_HP_DEF,
  parameter int unsigned INVULN_CYCLES = 65000000,
  parameter int unsigned BLINK_HALF    = 8125000
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [COORD_W-1:0] obstacle_x,
  input  logic [COORD_W-1:0] obstacle_y,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic               play_selected,
  input  logic               menu_on,
  output logic [HP_W-1:0]    hp,
  output logic               hit,
  output logic               invuln,
  output logic               blink,
  output logic               game_over
);

  localparam logic [HP_W-1:0] HP_FULL = HP_W'(MAX_HP);

  hp_state_e         state, state_next;
  logic              collide_r;
  logic [COORD_W-1:0] x_end, y_end;
  logic              overlap_c;
  logic              abort_c;
  logic              tmr_load, tmr_run, tmr_clear, tmr_done_c;
  logic [HP_W-1:0]   hp_d;
  logic              hit_d;

  // Obstacle pixel inside the player square; (0,0) means nothing is drawn.
  assign x_end     = player_x + COORD_W'(PLAYER_SIZE - 1);
  assign y_end     = player_y + COORD_W'(PLAYER_SIZE - 1);
  assign overlap_c = ((obstacle_x != '0) || (obstacle_y != '0)) &&
                     in_span(obstacle_x, player_x, x_end) &&
                     in_span(obstacle_y, player_y, y_end);

  assign abort_c = menu_on || !play_selected;

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; abort outranks a simultaneous collision.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (!abort_c) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (abort_c)        state_next = ST_IDLE;
        else if (collide_r) state_next = (hp > HP_W'(1)) ? ST_INVULN : ST_GAME_OVER;
      end
      ST_INVULN: begin
        if (abort_c)         state_next = ST_IDLE;
        else if (tmr_done_c) state_next = ST_ACTIVE;
      end
      ST_GAME_OVER: begin
        if (abort_c) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and timer controls.
  always_comb begin
    hp_d      = hp;
    hit_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_run   = 1'b0;
    tmr_clear = 1'b0;
    unique case (state)
      ST_IDLE: begin
        hp_d      = HP_FULL;
        tmr_clear = 1'b1;
      end
      ST_ACTIVE: begin
        if (abort_c) begin
          hp_d      = HP_FULL;
          tmr_clear = 1'b1;
        end else if (collide_r) begin
          hit_d = 1'b1;
          if (hp > HP_W'(1)) begin
            hp_d     = hp - HP_W'(1);
            tmr_load = 1'b1;
          end else begin
            hp_d = '0;
          end
        end
      end
      ST_INVULN: begin
        if (abort_c) begin
          hp_d      = HP_FULL;
          tmr_clear = 1'b1;
        end else begin
          tmr_run = 1'b1;
        end
      end
      ST_GAME_OVER: begin
        hp_d = abort_c ? HP_FULL : '0;
      end
      default: begin
        hp_d      = HP_FULL;
        tmr_clear = 1'b1;
      end
    endcase
  end

  // Output and collision-pipeline registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      collide_r <= 1'b0;
      hp        <= HP_FULL;
      hit       <= 1'b0;
      invuln    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      collide_r <= overlap_c;
      hp        <= hp_d;
      hit       <= hit_d;
      invuln    <= (state_next == ST_INVULN);
      game_over <= (state_next == ST_GAME_OVER);
    end
  end

  hp_countdown_timer #(
    .CYCLES     (INVULN_CYCLES),
    .BLINK_HALF (BLINK_HALF)
  ) u_timer (
    .pclk   (pclk),
    .rst    (rst),
    .load   (tmr_load),
    .run    (tmr_run),
    .clear  (tmr_clear),
    .done_c (tmr_done_c),
    .blink  (blink)
  );

endmodule

// File: tb/tb_collision_hp_tracker.sv
// Self-checking bench for collision_hp_tracker (small timing parameters).
module tb_collision_hp_tracker;

  localparam int P_SIZE  = 20;
  localparam int P_HP    = 5;
  localparam int P_INV   = 100;
  localparam int P_BLINK = 10;

  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] obstacle_x, obstacle_y, player_x, player_y;
  logic        play_selected, menu_on;
  logic [3:0]  hp;
  logic        hit, invuln, blink, game_over;

  int n_assert = 0;
  int n_fail   = 0;

  collision_hp_tracker #(
    .PLAYER_SIZE   (P_SIZE),
    .MAX_HP        (P_HP),
    .INVULN_CYCLES (P_INV),
    .BLINK_HALF    (P_BLINK)
  ) dut (
    .pclk          (pclk),
    .rst           (rst),
    .obstacle_x    (obstacle_x),
    .obstacle_y    (obstacle_y),
    .player_x      (player_x),
    .player_y      (player_y),
    .play_selected (play_selected),
    .menu_on       (menu_on),
    .hp            (hp),
    .hit           (hit),
    .invuln        (invuln),
    .blink         (blink),
    .game_over     (game_over)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int px;
    int py;
    int ox;
    int oy;
    bit exp_hit;
  } vec_t;

  vec_t vecs[10];

  // Reference model state, in game terms.
  bit m_active, m_over, m_hit, m_prev_ov;
  int m_hp, m_inv_left, m_inv_age;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_obs(input int ox, input int oy);
    obstacle_x = 12'(ox);
    obstacle_y = 12'(oy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    play_selected = 1'b0;
    menu_on = 1'b0;
    set_obs(0, 0);
    step();
    rst = 1'b0;
  endtask

  // Reset, place the player, then enter play.
  task automatic start_play(input int px, input int py);
    do_reset();
    player_x = 12'(px);
    player_y = 12'(py);
    play_selected = 1'b1;
    step();
  endtask

  function automatic bit ref_overlap(input int px, input int py, input int ox, input int oy);
    return (ox != 0 || oy != 0) && ox >= px && ox <= px + P_SIZE - 1 &&
           oy >= py && oy <= py + P_SIZE - 1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_over = 0; m_hit = 0; m_prev_ov = 0;
    m_hp = P_HP; m_inv_left = 0; m_inv_age = 0;
  endtask

  // One clock edge of game rules, using the inputs presented before the edge.
  task automatic model_edge();
    bit abort;
    if (rst) begin
      model_reset();
    end else begin
      abort = menu_on || !play_selected;
      m_hit = 0;
      if (m_over) begin
        if (abort) begin m_over = 0; m_hp = P_HP; end
      end else if (!m_active) begin
        if (!abort) m_active = 1;
      end else if (abort) begin
        m_active = 0; m_inv_left = 0; m_hp = P_HP;
      end else if (m_inv_left > 0) begin
        m_inv_left--; m_inv_age++;
      end else if (m_prev_ov) begin
        m_hit = 1;
        m_hp--;
        if (m_hp == 0) begin m_over = 1; m_active = 0; end
        else begin m_inv_left = P_INV; m_inv_age = 0; end
      end
      m_prev_ov = ref_overlap(int'(player_x), int'(player_y), int'(obstacle_x), int'(obstacle_y));
    end
  endtask

  function automatic int pack_out(input int h, input bit ht, input bit iv, input bit bl, input bit go);
    return h * 16 + int'(ht) * 8 + int'(iv) * 4 + int'(bl) * 2 + int'(go);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hits, guard;
    int rises[$];
    bit pb;

    vecs[0] = '{100, 200, 110, 210, 1'b1};
    vecs[1] = '{100, 200, 120, 210, 1'b0};
    vecs[2] = '{100, 200,   0,   0, 1'b0};
    vecs[3] = '{100, 200, 100, 200, 1'b1};
    vecs[4] = '{100, 200, 119, 219, 1'b1};
    vecs[5] = '{100, 200, 119, 220, 1'b0};
    vecs[6] = '{100, 200,  99, 210, 1'b0};
    vecs[7] = '{  0,   0,   0,   1, 1'b1};
    vecs[8] = '{  0,   0,  19,   0, 1'b1};
    vecs[9] = '{1004, 748, 1023, 767, 1'b1};

    player_x = '0;
    player_y = '0;
    do_reset();
    check("reset hp", hp, P_HP);
    check("reset flags", pack_out(0, hit, invuln, blink, game_over), 0);

    // Single-pixel overlap vectors: hit appears two edges after the obstacle.
    foreach (vecs[i]) begin
      start_play(vecs[i].px, vecs[i].py);
      set_obs(vecs[i].ox, vecs[i].oy);
      step();
      check($sformatf("vec%0d early hit", i), hit, 0);
      set_obs(0, 0);
      step();
      check($sformatf("vec%0d hit", i), hit, int'(vecs[i].exp_hit));
      check($sformatf("vec%0d hp", i), hp, vecs[i].exp_hit ? P_HP - 1 : P_HP);
    end

    // Invulnerability window length after one hit.
    start_play(100, 200);
    set_obs(110, 210);
    step();
    set_obs(0, 0);
    step();
    check("win hit", hit, 1);
    n = 0;
    for (int k = 0; k < 300 && invuln; k++) begin
      n++;
      step();
      if (n == 1) check("win hit one cycle", hit, 0);
    end
    check("win length", n, P_INV);
    check("win exit blink", blink, 0);
    check("win exit hp", hp, P_HP - 1);

    // Continuous overlap: one hp per window, blink period 2*BLINK_HALF.
    start_play(100, 200);
    set_obs(110, 210);
    hits = 0;
    pb = 1'b0;
    rises.delete();
    for (int k = 1; k <= 250; k++) begin
      step();
      if (hit) hits++;
      if (k == 2) check("hold first hit edge", hit, 1);
      if (blink && !pb) rises.push_back(k);
      pb = blink;
    end
    set_obs(0, 0);
    check("hold hits", hits, 3);
    check("hold hp", hp, 2);
    check("hold blink rises", rises.size(), 12);
    if (rises.size() >= 3) begin
      check("hold blink first", rises[0], 2 + P_BLINK);
      check("hold blink period a", rises[1] - rises[0], 2 * P_BLINK);
      check("hold blink period b", rises[2] - rises[1], 2 * P_BLINK);
    end

    // Five spaced hits to game over, then menu returns to idle.
    start_play(100, 200);
    for (int h = 0; h < P_HP; h++) begin
      set_obs(105, 205);
      step();
      set_obs(0, 0);
      step();
      check($sformatf("go hit%0d", h), hit, 1);
      check($sformatf("go hp%0d", h), hp, P_HP - 1 - h);
      guard = 0;
      while (invuln && guard < 200) begin
        step();
        guard++;
      end
    end
    check("go flag", game_over, 1);
    check("go invuln", invuln, 0);
    set_obs(110, 210);
    for (int k = 0; k < 5; k++) step();
    set_obs(0, 0);
    check("go hold hp", hp, 0);
    check("go hold flag", game_over, 1);
    check("go hold no hit", hit, 0);
    menu_on = 1'b1;
    step();
    check("go menu hp", hp, P_HP);
    check("go menu flag", game_over, 0);
    menu_on = 1'b0;

    // Collision and menu in the same cycle: abort wins.
    start_play(100, 200);
    set_obs(110, 210);
    step();
    set_obs(0, 0);
    menu_on = 1'b1;
    step();
    check("abort hit", hit, 0);
    check("abort hp", hp, P_HP);
    check("abort invuln", invuln, 0);
    step();
    check("abort later hit", hit, 0);
    menu_on = 1'b0;

    // Reset in the middle of an invulnerability window.
    start_play(100, 200);
    set_obs(110, 210);
    step();
    set_obs(0, 0);
    step();
    for (int k = 0; k < 49; k++) step();
    check("midrst pre invuln", invuln, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst hp", hp, P_HP);
    check("midrst flags", pack_out(0, hit, invuln, blink, game_over), 0);
    step();
    set_obs(110, 210);
    step();
    set_obs(0, 0);
    step();
    check("midrst replay hit", hit, 1);
    check("midrst replay hp", hp, P_HP - 1);

    // Randomized play checked against the game-rule model.
    do_reset();
    model_reset();
    for (int c = 0; c < 5000; c++) begin
      int mode, ox, oy;
      if (c % 300 == 0) begin
        player_x = 12'($urandom_range(0, 1023));
        player_y = 12'($urandom_range(0, 767));
      end
      rst = ($urandom_range(0, 1499) == 0);
      menu_on = ($urandom_range(0, 499) == 0);
      play_selected = ($urandom_range(0, 499) != 0);
      mode = $urandom_range(0, 7);
      if (mode < 2) begin
        ox = int'(player_x) + $urandom_range(0, 29) - 5;
        oy = int'(player_y) + $urandom_range(0, 29) - 5;
        if (ox < 0) ox = 0;
        if (oy < 0) oy = 0;
        if (ox > 4095) ox = 4095;
      end else if (mode < 5) begin
        ox = $urandom_range(0, 1023);
        oy = $urandom_range(0, 767);
      end else begin
        ox = 0;
        oy = 0;
      end
      set_obs(ox, oy);
      step();
      model_edge();
      check($sformatf("rand cyc%0d", c), pack_out(int'(hp), hit, invuln, blink, game_over),
            pack_out(m_hp, m_hit, m_inv_left > 0,
                     (m_inv_left > 0) && ((m_inv_age / P_BLINK) % 2 == 1), m_over));
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_hp_tracker.md
COLLISION_HP_TRACKER -- requirements
Module: collision_hp_tracker

Interface
REQ-001 Parameter PLAYER_SIZE, default 20: player square side length, in pixels.
REQ-002 Parameter MAX_HP, default 5: hit points at start of play.
REQ-003 Parameter INVULN_CYCLES, default 65000000: invulnerability duration after a hit (1 s at 65 MHz).
REQ-004 Parameter BLINK_HALF, default 8125000: half-period of the blink output, in cycles.
REQ-005 pclk  input  1  pixel clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 obstacle_x  input  12  hcount of the obstacle pixel currently drawn; 0 = none.
REQ-008 obstacle_y  input  12  vcount of the obstacle pixel currently drawn; 0 = none.
REQ-009 player_x  input  12  player top-left column, range 0..1023.
REQ-010 player_y  input  12  player top-left row, range 0..767.
REQ-011 play_selected  input  1  game session active.
REQ-012 menu_on  input  1  menu displayed; aborts play.
REQ-013 hp  output  4  remaining hit points.
REQ-014 hit  output  1  one-cycle pulse per accepted collision.
REQ-015 invuln  output  1  high while in INVULN.
REQ-016 blink  output  1  player-hide toggle while invulnerable; 0 otherwise.
REQ-017 game_over  output  1  high while in GAME_OVER.

Function
REQ-018 Obstacle pixel is valid when obstacle_x != 0 or obstacle_y != 0; (0,0) never counts as a collision.
REQ-019 Overlap means a valid obstacle pixel with player_x <= obstacle_x <= player_x+PLAYER_SIZE-1 and player_y <= obstacle_y <= player_y+PLAYER_SIZE-1; sums are 12-bit unsigned and cannot overflow in range.
REQ-020 Overlap is registered into collide_r; collide_r sampled at edge k acts on the FSM at edge k+1 (2-cycle latency input to hit/hp).
REQ-021 FSM has states IDLE, ACTIVE, INVULN and GAME_OVER.
REQ-022 IDLE: hp=MAX_HP, all flags 0; go to ACTIVE when play_selected && !menu_on.
REQ-023 ACTIVE with collide_r=1 and hp>1: hp decrements by 1, hit=1 for one cycle, timer loads INVULN_CYCLES-1, and the FSM goes to INVULN.
REQ-024 ACTIVE with collide_r=1 and hp==1: hp becomes 0, hit=1 for one cycle, and the FSM goes to GAME_OVER.
REQ-025 INVULN: timer decrements each cycle, collisions are ignored, invuln=1, and blink toggles every BLINK_HALF cycles starting at 0; when the timer reaches 0 the FSM goes to ACTIVE with blink=0.
REQ-026 GAME_OVER: game_over=1 and hp=0 are held; go to IDLE when menu_on || !play_selected.
REQ-027 In ACTIVE or INVULN, menu_on || !play_selected forces IDLE next cycle and hp returns to MAX_HP; abort takes priority over a simultaneous collision (no hit, no decrement).
REQ-028 Continuous overlap across many cycles costs exactly one hp per invulnerability window.
REQ-029 hp never underflows below 0 and never exceeds MAX_HP.

Reset
REQ-030 On rst: state=IDLE, hp=MAX_HP, hit=0, invuln=0, blink=0, game_over=0, collide_r=0, timer=0.
REQ-031 rst asserted mid-INVULN or mid-GAME_OVER gives the REQ-030 values on the next edge, with no residual hit pulse.

Structure
REQ-032 The state encoding, PLAYER_SIZE and MAX_HP defaults SHALL live in the shared game package.
REQ-033 The invulnerability countdown plus blink divider SHALL be one sub-module, hp_countdown_timer (load, count-down, done, blink).
REQ-034 All outputs SHALL be registered; there are no combinational input-to-output paths.

Verification (sim parameters: INVULN_CYCLES=100, BLINK_HALF=10, MAX_HP=5, PLAYER_SIZE=20)
REQ-035 Scenario: player (100,200), obstacle (110,210) for 1 cycle -> hit pulses 2 cycles later, hp 5->4, invuln=1 for exactly 100 cycles.
REQ-036 Scenario: obstacle (120,210) or (0,0) with player at (100,200) -> no hit, hp stays 5.
REQ-037 Scenario: obstacle held overlapping for 250 cycles -> exactly 3 hits, hp=2, blink period 20 cycles during each INVULN.
REQ-038 Scenario: 5 hits spaced after invuln expiry -> hp=0, game_over=1; then menu_on=1 -> IDLE, hp=5, game_over=0.
REQ-039 Scenario: collide_r and menu_on in the same cycle in ACTIVE -> no hit, hp=5, state IDLE.
REQ-040 Scenario: rst at INVULN cycle 50 -> next edge hp=5, invuln=0, blink=0; play_selected=1 -> ACTIVE.
